// File: rtl/ifetch_queue.sv
// ifetch_queue: PC owner that fetches from instruction memory and queues instructions for decode.
module ifetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int ADDR_W = 10,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [1:0]        imem_word,
  output logic              imem_cs,
  input  logic [63:0]       imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [63:0]       out_pc,
  output logic              out_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = {{(ADDR_W-2){1'b1}}, 2'b00};
  typedef enum logic {RUN, FAULTED} state_t;
  state_t state;
  logic [63:0] pc;
  logic [63:0] pc_q [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic [DEPTH-1:0] fault_q;
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count;
  logic pop, fetch, fault_addr;
  logic unused_hi;
  assign unused_hi = ^imem_data[63:32];
  always_comb begin
    pop = out_valid && out_ready;
    fetch = (state == RUN) && !halt && !redirect_valid && !rst && ((count < FULL) || pop);
    fault_addr = (|pc[1:0]) || (|pc[63:ADDR_W]) || (pc[ADDR_W-1:0] > LAST);
  end
  assign imem_cs = fetch;
  assign imem_addr = pc[ADDR_W-1:0];
  assign imem_word = 2'b10;
  assign out_valid = count != '0;
  assign out_inst = out_valid ? inst_q[rd] : '0;
  assign out_pc = out_valid ? pc_q[rd] : '0;
  assign out_fault = out_valid && fault_q[rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      state <= RUN;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      state <= RUN;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (fetch) begin
        pc_q[wr] <= pc;
        inst_q[wr] <= fault_addr ? 32'h0 : imem_data[31:0];
        fault_q[wr] <= fault_addr;
        wr <= wr + 1'b1;
        // a faulting PC is kept so the fault entry and any later inspection see it
        if (fault_addr) state <= FAULTED;
        else pc <= pc + 64'd4;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(fetch) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: table-driven per-cycle vectors plus a throughput sequence for ifetch_queue.
module tb_ifetch_queue;
  logic clk = 0, rst = 1, halt = 0, redirect_valid = 0, out_ready = 0;
  logic [63:0] redirect_pc = '0, imem_data, out_pc;
  logic [9:0] imem_addr;
  logic [1:0] imem_word;
  logic imem_cs, out_valid, out_fault;
  logic [31:0] out_inst;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  ifetch_queue #(.RESET_PC(64'h0), .ADDR_W(10), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_word(imem_word),
    .imem_cs(imem_cs), .imem_data(imem_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_fault(out_fault)
  );
  function automatic logic [31:0] inst_of(logic [9:0] a);
    return {a, 15'h0, 7'h13};
  endfunction
  assign imem_data = {32'hDEADBEEF, inst_of(imem_addr)};
  typedef struct {
    logic rst, halt, rv;
    logic [63:0] rpc;
    logic rdy, cs;
    logic [9:0] addr;
    logic ov;
    logic [63:0] opc;
    logic flt;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(logic r, logic h, logic rv, logic [63:0] rpc, logic rdy,
                             logic cs, logic [9:0] addr, logic ov, logic [63:0] opc, logic flt);
    vec_t x;
    x.rst = r; x.halt = h; x.rv = rv; x.rpc = rpc; x.rdy = rdy;
    x.cs = cs; x.addr = addr; x.ov = ov; x.opc = opc; x.flt = flt;
    return x;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic drive(logic r, logic h, logic rv, logic [63:0] rpc, logic rdy);
    @(negedge clk);
    rst = r; halt = h; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1;
  endtask
  initial begin
    int n;
    // rst  halt rv  rpc  rdy | cs addr ov opc flt
    tbl.push_back(v(1,0,0,0,1, 0,10'h000,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h000,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h004,1,64'h0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h008,1,64'h4,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h00C,1,64'h8,0));
    tbl.push_back(v(1,0,0,0,1, 0,10'h010,1,64'hC,0));
    tbl.push_back(v(0,0,0,0,0, 1,10'h000,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,10'h004,1,64'h0,0));
    tbl.push_back(v(0,0,0,0,0, 0,10'h008,1,64'h0,0));
    tbl.push_back(v(0,0,0,0,0, 0,10'h008,1,64'h0,0));
    tbl.push_back(v(0,0,0,0,0, 0,10'h008,1,64'h0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h008,1,64'h0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h00C,1,64'h4,0));
    tbl.push_back(v(0,0,1,64'h40,1, 0,10'h010,1,64'h8,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h040,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h044,1,64'h40,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h048,1,64'h44,0));
    tbl.push_back(v(0,1,0,0,1, 0,10'h04C,1,64'h48,0));
    tbl.push_back(v(0,1,0,0,1, 0,10'h04C,0,0,0));
    tbl.push_back(v(0,1,0,0,1, 0,10'h04C,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h04C,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h050,1,64'h4C,0));
    tbl.push_back(v(0,0,1,64'h42,1, 0,10'h054,1,64'h50,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h042,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,10'h042,1,64'h42,1));
    tbl.push_back(v(0,0,0,0,1, 0,10'h042,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,10'h042,0,0,0));
    tbl.push_back(v(0,0,1,64'h100,1, 0,10'h042,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h100,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h104,1,64'h100,0));
    tbl.push_back(v(0,0,1,64'h3F8,1, 0,10'h108,1,64'h104,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h3F8,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h3FC,1,64'h3F8,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h000,1,64'h3FC,0));
    tbl.push_back(v(0,0,0,0,1, 0,10'h000,1,64'h400,1));
    tbl.push_back(v(0,0,0,0,1, 0,10'h000,0,0,0));
    tbl.push_back(v(0,0,1,64'h1_0000_0000,1, 0,10'h000,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h000,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,10'h000,1,64'h1_0000_0000,1));
    tbl.push_back(v(1,0,1,64'h200,1, 0,10'h000,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h000,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,10'h004,1,64'h0,0));
    drive(1,0,0,0,0);
    drive(1,0,0,0,0);
    chk("reset_valid", out_valid, 0);
    chk("reset_pc", out_pc, 0);
    chk("reset_inst", out_inst, 0);
    chk("reset_fault", out_fault, 0);
    chk("reset_cs", imem_cs, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].halt, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("row%0d_cs", i), imem_cs, tbl[i].cs);
      chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("row%0d_word", i), imem_word, 2'b10);
      chk($sformatf("row%0d_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].ov) begin
        chk($sformatf("row%0d_pc", i), out_pc, tbl[i].opc);
        chk($sformatf("row%0d_inst", i), out_inst, tbl[i].flt ? 32'h0 : inst_of(tbl[i].opc[9:0]));
        chk($sformatf("row%0d_fault", i), out_fault, tbl[i].flt);
      end
    end
    // steady-state stream after a redirect: one instruction per cycle, no gaps
    drive(0,0,1,64'h20,1);
    drive(0,0,0,0,1);
    n = 0;
    while (!out_valid && n < 4) begin
      drive(0,0,0,0,1);
      n++;
    end
    chk("tput_first_valid", out_valid, 1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("tput%0d_valid", k), out_valid, 1);
      chk($sformatf("tput%0d_pc", k), out_pc, 64'h20 + 64'(4 * k));
      chk($sformatf("tput%0d_inst", k), out_inst, inst_of(10'(32'h20 + 4 * k)));
      drive(0,0,0,0,1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the byte-addressed instruction memory.
- Owns the PC and drives the memory's addr/word/cs each cycle. Captures the 32-bit instruction returned combinationally in the same cycle.
- Buffers fetched instructions in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump/trap) flush, a halt input, and detection of misaligned or out-of-range fetch addresses.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- ADDR_W, 10, byte-address width of the instruction memory; fetchable range is 0 .. 2^ADDR_W-4.
- DEPTH, 2, FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- halt  input  1  level; while 1, no new fetch is issued (FIFO still drains)
- redirect_valid  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  64  new fetch PC
- imem_addr  output  ADDR_W  byte address to instruction memory (= pc[ADDR_W-1:0])
- imem_word  output  2  access size; constant 2'b10 (32-bit)
- imem_cs  output  1  memory chip select, 1 only in a fetch cycle
- imem_data  input  64  memory read data; instruction = imem_data[31:0], valid in the same cycle cs=1
- out_valid  output  1  FIFO head valid
- out_ready  input  1  decode accepts head
- out_inst  output  32  head instruction
- out_pc  output  64  head PC
- out_fault  output  1  head is a fetch fault (inst field = 0)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - pc = RESET_PC, FIFO empty, state = RUN.
  - out_valid = 0, out_inst = 0, out_pc = 0, out_fault = 0.
  - imem_cs = 0 during any cycle with rst = 1.
  - rst overrides redirect and halt.
- States: RUN, FAULTED.
- pop = out_valid & out_ready.
- fetch = (state == RUN) & !halt & !redirect_valid & !rst & (count < DEPTH | pop).
  - A slot freed by a pop is reusable in the same cycle.
- imem_cs = fetch, combinational. imem_addr = pc[ADDR_W-1:0] always. imem_word = 2'b10 always.
- fault_addr = (pc[1:0] != 0) | (pc[63:ADDR_W] != 0) | (pc[ADDR_W-1:0] > 2^ADDR_W-4).
- On fetch & !fault_addr:
  - Push {pc, imem_data[31:0], fault=0}.
  - pc <= pc + 4 (64-bit wrap, no special handling).
- On fetch & fault_addr:
  - Push {pc, 32'h0, fault=1}.
  - pc unchanged.
  - imem_cs is still 1 this cycle; the data is ignored.
  - state <= FAULTED.
- FAULTED: no fetch issued. Remains in FAULTED until redirect_valid.
- redirect_valid (highest priority after rst):
  - FIFO emptied at the clock edge; any same-cycle pop is discarded.
  - pc <= redirect_pc; state <= RUN; no push that cycle.
  - out_valid = 0 in the following cycle; the first new fetch is issued that cycle.
- halt: suppresses fetch only. Pops, redirect and fault state are unaffected. pc holds.
- Latency: an instruction fetched in cycle N is visible on out_* in cycle N+1 (registered FIFO head). Steady-state throughput is 1 instr/cycle with out_ready held high.
- FIFO ordering:
  - Strict order.
  - Simultaneous push and pop keeps count.
  - Pop with FIFO empty is impossible (out_valid = 0).
  - out_* hold their value while out_valid & !out_ready.
- Backpressure: with out_ready = 0 the FIFO fills to DEPTH; fetch stops and pc holds at the next unfetched address.

Test Plan:
- Reset, RESET_PC = 0, memory words 0x00000013, 0x00100093, ..., out_ready = 1:
  - cs = 1 every cycle.
  - out_pc sequence 0, 4, 8, ..., starting one cycle after reset release, with matching out_inst.
- Backpressure:
  - out_ready = 0 for 5 cycles: out_valid = 1 with head pc 0 stable; fetch stops after 2 pushes (cs = 0 from the third cycle); pc = 8.
  - Release out_ready: pcs 0, 4, 8 delivered in order with no gaps or duplicates.
- Redirect to 0x40 while the FIFO holds pcs 8 and 12, with out_ready = 1 in the same cycle:
  - Next cycle out_valid = 0 and imem_addr = 0x40.
  - Cycle after: out_pc = 0x40; pc 8 never re-emitted.
- Misaligned redirect to 0x42:
  - One entry with out_fault = 1, out_pc = 0x42, out_inst = 0.
  - cs stays 0 afterward until redirect to 0x100, which resumes fetch.
- Range fault, ADDR_W = 10:
  - Sequential fetch reaches 0x3FC normally.
  - pc 0x400 yields a fault entry, then the block enters FAULTED.
- Halt: halt = 1 for 3 cycles mid-stream gives cs = 0, pc frozen and the FIFO drains; halt = 0 resumes fetch at the frozen pc. Also assert rst mid-stream: next cycle FIFO empty and pc = RESET_PC.
